// File: rtl/uip_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uip_regs_pkg
//  Purpose  : Shared register map, response codes, write-FSM state type and
//             byte-strobe merge helper for the user-IP AXI4-Lite register bank.
//  Revision : 1.0  initial release
// ============================================================================
package uip_regs_pkg;

   // Byte offsets of the register map (bits [1:0] are ignored by decode)
   localparam logic [31:0] OFF_ID      = 32'h0000_0000;
   localparam logic [31:0] OFF_SCRATCH = 32'h0000_0004;
   localparam logic [31:0] OFF_CTRL    = 32'h0000_0008;
   localparam logic [31:0] OFF_STATUS  = 32'h0000_000C;
   localparam logic [31:0] OFF_COUNTER = 32'h0000_0010;
   localparam logic [31:0] OFF_USER0   = 32'h0000_0014;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE      = 2'd0,
      WR_HAVE_ADDR = 2'd1,
      WR_HAVE_DATA = 2'd2,
      WR_RESP      = 2'd3
   } t_wr_state;

   // Replace only the bytes whose strobe is set
   function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                              input logic [31:0] nxt,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? nxt[8*b +: 8] : cur[8*b +: 8];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_wr_join.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_wr_join
//  Purpose  : Captures AXI4-Lite AW and W independently (either order), joins
//             them into a one-cycle register write strobe and owns the B channel.
//  Revision : 1.0  initial release
// ============================================================================
module axi4lite_wr_join
   import uip_regs_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [1:0]        wr_resp,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [3:0]        wr_strb
);

   t_wr_state         state;
   logic              live;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [3:0]        strb_q;
   logic [1:0]        bresp_q;
   logic              aw_hs;
   logic              w_hs;

   // live keeps readies low during reset and lets them rise one cycle after release
   assign awready = live && ((state == WR_IDLE) || (state == WR_HAVE_DATA));
   assign wready  = live && ((state == WR_IDLE) || (state == WR_HAVE_ADDR));
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;

   // The write fires in the cycle the second half arrives; captured halves bypass the inputs
   assign wr_en   = (aw_hs || (state == WR_HAVE_ADDR)) && (w_hs || (state == WR_HAVE_DATA));
   assign wr_addr = (state == WR_HAVE_ADDR) ? addr_q : awaddr;
   assign wr_data = (state == WR_HAVE_DATA) ? data_q : wdata;
   assign wr_strb = (state == WR_HAVE_DATA) ? strb_q : wstrb;

   assign bvalid  = (state == WR_RESP);
   assign bresp   = bresp_q;

   // Capture halves, latch the response and sequence IDLE/HAVE_x/RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= WR_IDLE;
         live    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         bresp_q <= RESP_OKAY;
      end else begin
         live <= 1'b1;
         if (aw_hs) addr_q <= awaddr;
         if (w_hs) begin
            data_q <= wdata;
            strb_q <= wstrb;
         end
         if (wr_en) bresp_q <= wr_resp;
         case (state)
            WR_IDLE: begin
               if (wr_en)      state <= WR_RESP;
               else if (aw_hs) state <= WR_HAVE_ADDR;
               else if (w_hs)  state <= WR_HAVE_DATA;
            end
            WR_HAVE_ADDR: if (wr_en) state <= WR_RESP;
            WR_HAVE_DATA: if (wr_en) state <= WR_RESP;
            WR_RESP:      if (bready) state <= WR_IDLE;
            default:      state <= WR_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi4lite_uip_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_uip_reg_slave
//  Purpose  : AXI4-Lite register bank for the user-IP side of the CCI-P MMIO
//             path: ID, scratch, control, status, cycle counter, user regs.
//  Revision : 1.0  initial release
// ============================================================================
module axi4lite_uip_reg_slave
   import uip_regs_pkg::*;
#(
   parameter int          ADDR_W        = 16,
   parameter int          NUM_USER_REGS = 4,
   parameter logic [31:0] ID_VALUE      = 32'h5549_5031
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADDR_W-1:0]          s_axi_awaddr,
   input  logic                       s_axi_awvalid,
   output logic                       s_axi_awready,
   input  logic [31:0]                s_axi_wdata,
   input  logic [3:0]                 s_axi_wstrb,
   input  logic                       s_axi_wvalid,
   output logic                       s_axi_wready,
   output logic [1:0]                 s_axi_bresp,
   output logic                       s_axi_bvalid,
   input  logic                       s_axi_bready,
   input  logic [ADDR_W-1:0]          s_axi_araddr,
   input  logic                       s_axi_arvalid,
   output logic                       s_axi_arready,
   output logic [31:0]                s_axi_rdata,
   output logic [1:0]                 s_axi_rresp,
   output logic                       s_axi_rvalid,
   input  logic                       s_axi_rready,
   input  logic                       activated_i,
   output logic                       ctrl_enable_o,
   output logic [32*NUM_USER_REGS-1:0] user_regs_o
);

   localparam logic [0:0] RD_IDLE = 1'b0;
   localparam logic [0:0] RD_DATA = 1'b1;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [3:0]        wr_strb;
   logic [1:0]        wr_resp;
   logic [31:0]       wr_a;
   logic [31:0]       rd_a;
   logic              wr_ctrl;
   logic              cnt_clr;
   logic [31:0]       scratch_q;
   logic              enable_q;
   logic [31:0]       counter_q;
   logic              status_q;
   logic [31:0]       user_q [NUM_USER_REGS];
   logic [0:0]        rd_state;
   logic              rd_live;
   logic [31:0]       rd_data;
   logic [1:0]        rd_resp;
   logic [31:0]       rdata_q;
   logic [1:0]        rresp_q;

   function automatic logic is_mapped(input logic [31:0] a);
      return (a <= OFF_COUNTER) ||
             ((a >= OFF_USER0) && (a < OFF_USER0 + 32'(4*NUM_USER_REGS)));
   endfunction

   axi4lite_wr_join #(.ADDR_W(ADDR_W)) u_wr_join (
      .clk     (clk),
      .rst_n   (rst_n),
      .awaddr  (s_axi_awaddr),
      .awvalid (s_axi_awvalid),
      .awready (s_axi_awready),
      .wdata   (s_axi_wdata),
      .wstrb   (s_axi_wstrb),
      .wvalid  (s_axi_wvalid),
      .wready  (s_axi_wready),
      .bresp   (s_axi_bresp),
      .bvalid  (s_axi_bvalid),
      .bready  (s_axi_bready),
      .wr_resp (wr_resp),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_strb (wr_strb)
   );

   // Word-aligned addresses used for decode
   assign wr_a    = 32'(wr_addr) & ~32'h3;
   assign rd_a    = 32'(s_axi_araddr) & ~32'h3;
   assign wr_resp = is_mapped(wr_a) ? RESP_OKAY : RESP_SLVERR;
   assign wr_ctrl = wr_en && (wr_a == OFF_CTRL);
   assign cnt_clr = wr_ctrl && wr_strb[0] && wr_data[1];

   // Scratch, control enable and registered status flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scratch_q <= '0;
         enable_q  <= 1'b0;
         status_q  <= 1'b0;
      end else begin
         status_q <= activated_i;
         if (wr_en && (wr_a == OFF_SCRATCH)) scratch_q <= apply_strb(scratch_q, wr_data, wr_strb);
         if (wr_ctrl && wr_strb[0])          enable_q  <= wr_data[0];
      end
   end

   // Free-running counter; a clear request beats the increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        counter_q <= '0;
      else if (cnt_clr)  counter_q <= '0;
      else if (enable_q) counter_q <= counter_q + 32'd1;
   end

   // User register bank with per-byte write strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_USER_REGS; k++) user_q[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_USER_REGS; k++) begin
            if (wr_en && (wr_a == OFF_USER0 + 32'(4*k)))
               user_q[k] <= apply_strb(user_q[k], wr_data, wr_strb);
         end
      end
   end

   for (genvar k = 0; k < NUM_USER_REGS; k++) begin : g_user_out
      assign user_regs_o[32*k +: 32] = user_q[k];
   end

   assign ctrl_enable_o = enable_q;

   // Read decode; unmapped offsets return zero with SLVERR
   always_comb begin
      rd_data = '0;
      rd_resp = RESP_SLVERR;
      case (rd_a)
         OFF_ID:      begin rd_data = ID_VALUE;             rd_resp = RESP_OKAY; end
         OFF_SCRATCH: begin rd_data = scratch_q;            rd_resp = RESP_OKAY; end
         OFF_CTRL:    begin rd_data = {31'd0, enable_q};    rd_resp = RESP_OKAY; end
         OFF_STATUS:  begin rd_data = {31'd0, status_q};    rd_resp = RESP_OKAY; end
         OFF_COUNTER: begin rd_data = counter_q;            rd_resp = RESP_OKAY; end
         default:     ;
      endcase
      for (int k = 0; k < NUM_USER_REGS; k++) begin
         if (rd_a == OFF_USER0 + 32'(4*k)) begin
            rd_data = user_q[k];
            rd_resp = RESP_OKAY;
         end
      end
   end

   assign s_axi_arready = rd_live && (rd_state == RD_IDLE);
   assign s_axi_rvalid  = (rd_state == RD_DATA);
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;

   // Read FSM: one outstanding read, data registered at the AR handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= RD_IDLE;
         rd_live  <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         rd_live <= 1'b1;
         case (rd_state)
            RD_IDLE: begin
               if (s_axi_arvalid && s_axi_arready) begin
                  rdata_q  <= rd_data;
                  rresp_q  <= rd_resp;
                  rd_state <= RD_DATA;
               end
            end
            RD_DATA: if (s_axi_rready) rd_state <= RD_IDLE;
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_uip_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4lite_uip_reg_slave
//  Purpose  : Self-checking bench for axi4lite_uip_reg_slave with a register-
//             map reference model and directed plus random AXI4-Lite traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4lite_uip_reg_slave;

   localparam int          ADDR_W = 16;
   localparam int          NUM    = 4;
   localparam logic [31:0] IDV    = 32'h5549_5031;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   logic [31:0]       wdata, rdata;
   logic [3:0]        wstrb;
   logic [1:0]        bresp, rresp;
   logic              activated, ctrl_en;
   logic [32*NUM-1:0] user_regs;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_scratch;
   logic        m_en;
   logic [31:0] m_user [NUM];

   axi4lite_uip_reg_slave #(.ADDR_W(ADDR_W), .NUM_USER_REGS(NUM), .ID_VALUE(IDV)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .activated_i(activated), .ctrl_enable_o(ctrl_en), .user_regs_o(user_regs)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_scratch = '0;
      m_en      = 1'b0;
      for (int k = 0; k < NUM; k++) m_user[k] = '0;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] nxt, input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (cur & ~mask) | (nxt & mask);
   endfunction

   function automatic logic [1:0] model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
      int w;
      w = int'(a >> 2);
      if (w == 1) m_scratch = merge(m_scratch, d, s);
      else if (w == 2) begin if (s[0]) m_en = d[0]; end
      else if (w >= 5 && w < 5 + NUM) m_user[w-5] = merge(m_user[w-5], d, s);
      else if (w > 4) return 2'b10;
      return 2'b00;
   endfunction

   function automatic void model_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                                      output logic [1:0] r, output bit cnt);
      int w;
      w = int'(a >> 2);
      d = '0; r = 2'b00; cnt = 1'b0;
      if (w == 0) d = IDV;
      else if (w == 1) d = m_scratch;
      else if (w == 2) d = {31'd0, m_en};
      else if (w == 3) d = {31'd0, activated};
      else if (w == 4) cnt = 1'b1;
      else if (w >= 5 && w < 5 + NUM) d = m_user[w-5];
      else r = 2'b10;
   endfunction

   function automatic logic [32*NUM-1:0] m_flat();
      logic [32*NUM-1:0] f;
      for (int k = 0; k < NUM; k++) f[32*k +: 32] = m_user[k];
      return f;
   endfunction

   // ---------------- bus drivers (no checking) ----------------
   task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input bit brdy,
                            output logic [1:0] resp, output int lat, output bit to);
      bit aw_ok, w_ok, aw_now, w_now;
      int cyc;
      aw_ok = 0; w_ok = 0; to = 0; lat = 0; cyc = 0;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = (w_lead == 0); bready = brdy;
      while (!(aw_ok && w_ok)) begin
         aw_now = awvalid && awready;
         w_now  = wvalid && wready;
         @(negedge clk);
         cyc++;
         if (aw_now) begin awvalid = 1'b0; aw_ok = 1; end
         if (w_now)  begin wvalid  = 1'b0; w_ok  = 1; end
         if (!aw_ok && !awvalid && cyc >= w_lead) awvalid = 1'b1;
         if (cyc > 40) begin to = 1; awvalid = 1'b0; wvalid = 1'b0; break; end
      end
      while (!bvalid && !to) begin
         @(negedge clk);
         lat++;
         if (lat > 20) to = 1;
      end
      resp = bresp;
      if (brdy) @(negedge clk);
   endtask

   task automatic axi_read(input logic [ADDR_W-1:0] a, input bit rrdy,
                           output logic [31:0] d, output logic [1:0] r, output bit to);
      int cyc;
      to = 0; cyc = 0;
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = rrdy;
      while (!arready) begin
         @(negedge clk);
         cyc++;
         if (cyc > 20) begin to = 1; break; end
      end
      @(negedge clk);
      arvalid = 1'b0;
      cyc = 0;
      while (!rvalid && !to) begin
         @(negedge clk);
         cyc++;
         if (cyc > 20) to = 1;
      end
      d = rdata; r = rresp;
      if (rrdy) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #3;
      n_checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin n_fail++;
         $display("FAIL reset_handshake: got %b, required 00000", {awready, wready, arready, bvalid, rvalid}); end
      n_checks++; if ({bresp, rresp, rdata} !== 36'd0) begin n_fail++;
         $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h, required zeros", bresp, rresp, rdata); end
      n_checks++; if ({ctrl_en, user_regs} !== '0) begin n_fail++;
         $display("FAIL reset_regs: got ctrl=%b user=%h, required zeros", ctrl_en, user_regs); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if ({awready, wready, arready} !== 3'b111) begin n_fail++;
         $display("FAIL ready_after_reset: got %b, required 111", {awready, wready, arready}); end
   endtask

   task automatic test_scratch();
      logic [1:0] r, exp_r; logic [31:0] d; int lat; bit to;
      exp_r = model_write(16'h0004, 32'hDEAD_BEEF, 4'hF);
      axi_write(16'h0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, r, lat, to);
      n_checks++; if (to || lat != 0 || r !== exp_r) begin n_fail++;
         $display("FAIL scratch_write: got to=%0d lat=%0d resp=%b, required lat=0 resp=%b", to, lat, r, exp_r); end
      n_checks++; if (bvalid !== 1'b0) begin n_fail++;
         $display("FAIL scratch_bdone: got bvalid=%b, required 0", bvalid); end
      axi_read(16'h0004, 1'b1, d, r, to);
      n_checks++; if (to || d !== 32'hDEAD_BEEF || r !== 2'b00) begin n_fail++;
         $display("FAIL scratch_read: got %h/%b, required deadbeef/00", d, r); end
   endtask

   task automatic test_w_before_aw();
      logic [1:0] r, exp_r; int lat; bit to;
      exp_r = model_write(16'h0014, 32'h1234_5678, 4'h3);
      axi_write(16'h0014, 32'h1234_5678, 4'h3, 3, 1'b1, r, lat, to);
      n_checks++; if (to || lat != 0 || r !== exp_r) begin n_fail++;
         $display("FAIL w_first_write: got to=%0d lat=%0d resp=%b, required lat=0 resp=%b", to, lat, r, exp_r); end
      n_checks++; if (user_regs[31:0] !== 32'h0000_5678 || user_regs !== m_flat()) begin n_fail++;
         $display("FAIL w_first_user: got %h, required %h", user_regs, m_flat()); end
   endtask

   task automatic test_decode();
      logic [1:0] r; logic [31:0] d; int lat; bit to;
      axi_read(16'h0000, 1'b1, d, r, to);
      n_checks++; if (to || d !== IDV || r !== 2'b00) begin n_fail++;
         $display("FAIL id_read: got %h/%b, required %h/00", d, r, IDV); end
      axi_read(16'h0040, 1'b1, d, r, to);
      n_checks++; if (to || d !== 32'd0 || r !== 2'b10) begin n_fail++;
         $display("FAIL unmapped_read: got %h/%b, required 0/10", d, r); end
      axi_write(16'h0040, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, r, lat, to);
      n_checks++; if (to || r !== model_write(16'h0040, 32'hFFFF_FFFF, 4'hF) || user_regs !== m_flat()) begin n_fail++;
         $display("FAIL unmapped_write: got resp=%b user=%h, required 10 and %h", r, user_regs, m_flat()); end
      axi_write(16'h0000, 32'h0, 4'hF, 1, 1'b1, r, lat, to);
      axi_read(16'h0000, 1'b1, d, r, to);
      n_checks++; if (to || d !== IDV) begin n_fail++;
         $display("FAIL id_readonly: got %h, required %h", d, IDV); end
      activated = 1'b1;
      axi_read(16'h000C, 1'b1, d, r, to);
      n_checks++; if (to || d !== 32'd1 || r !== 2'b00) begin n_fail++;
         $display("FAIL status_read: got %h/%b, required 1/00", d, r); end
   endtask

   task automatic test_counter();
      logic [1:0] r; logic [31:0] d; int lat; bit to;
      void'(model_write(16'h0008, 32'h1, 4'hF));
      axi_write(16'h0008, 32'h1, 4'hF, 0, 1'b1, r, lat, to);
      n_checks++; if (ctrl_en !== 1'b1) begin n_fail++;
         $display("FAIL ctrl_enable: got %b, required 1", ctrl_en); end
      repeat (8) @(negedge clk);
      axi_read(16'h0010, 1'b1, d, r, to);
      n_checks++; if (to || d < 32'd9 || d > 32'd11) begin n_fail++;
         $display("FAIL counter_run: got %0d, required 9..11", d); end
      // CTRL=3 then a read issued the very next cycle must see the cleared counter
      @(negedge clk);
      awaddr = 16'h0008; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n_checks++; if ({awready, wready} !== 2'b11) begin n_fail++;
         $display("FAIL clr_ready: got %b, required 11", {awready, wready}); end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; araddr = 16'h0010; arvalid = 1'b1; rready = 1'b1;
      n_checks++; if (bvalid !== 1'b1) begin n_fail++;
         $display("FAIL clr_bvalid: got %b, required 1", bvalid); end
      @(negedge clk);
      arvalid = 1'b0;
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'd0) begin n_fail++;
         $display("FAIL counter_clear: got rvalid=%b data=%0d, required 1/0", rvalid, rdata); end
      @(negedge clk);
      void'(model_write(16'h0008, 32'h3, 4'hF));
      axi_read(16'h0008, 1'b1, d, r, to);
      n_checks++; if (to || d !== {31'd0, m_en}) begin n_fail++;
         $display("FAIL ctrl_read: got %h, required %h", d, {31'd0, m_en}); end
   endtask

   task automatic test_backpressure();
      logic [1:0] r, exp_r; logic [31:0] d, held; int lat; bit to;
      exp_r = model_write(16'h0018, 32'hA5A5_0F0F, 4'hF);
      axi_write(16'h0018, 32'hA5A5_0F0F, 4'hF, 0, 1'b0, r, lat, to);
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (to || bvalid !== 1'b1 || {awready, wready} !== 2'b00 || bresp !== exp_r) begin n_fail++;
            $display("FAIL b_hold cyc%0d: got bvalid=%b rdy=%b bresp=%b, required 1/00/%b", i, bvalid, {awready, wready}, bresp, exp_r); end
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      n_checks++; if (bvalid !== 1'b0 || {awready, wready} !== 2'b11) begin n_fail++;
         $display("FAIL b_release: got bvalid=%b rdy=%b, required 0/11", bvalid, {awready, wready}); end
      axi_read(16'h0018, 1'b0, held, r, to);
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (to || rvalid !== 1'b1 || arready !== 1'b0 || rdata !== m_user[1]) begin n_fail++;
            $display("FAIL r_hold cyc%0d: got rvalid=%b arready=%b data=%h, required 1/0/%h", i, rvalid, arready, rdata, m_user[1]); end
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      n_checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_fail++;
         $display("FAIL r_release: got rvalid=%b arready=%b, required 0/1", rvalid, arready); end
      d = held;
   endtask

   task automatic test_same_cycle();
      logic [31:0] old_v, d; logic [1:0] r; bit to;
      old_v = m_scratch;
      @(negedge clk);
      awaddr = 16'h0004; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      araddr = 16'h0004; arvalid = 1'b1; rready = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      n_checks++; if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old_v) begin n_fail++;
         $display("FAIL same_cycle: got rvalid=%b bvalid=%b data=%h, required 1/1/%h", rvalid, bvalid, rdata, old_v); end
      @(negedge clk);
      void'(model_write(16'h0004, 32'h0BAD_F00D, 4'hF));
      axi_read(16'h0004, 1'b1, d, r, to);
      n_checks++; if (to || d !== m_scratch) begin n_fail++;
         $display("FAIL same_cycle_after: got %h, required %h", d, m_scratch); end
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] a; logic [31:0] dat, d, ed; logic [3:0] s; logic [1:0] r, er; int lat; bit to, cnt;
      for (int i = 0; i < 40; i++) begin
         activated = 1'($urandom_range(0, 1));
         a   = ADDR_W'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = a | 16'h8000;
         dat = $urandom;
         s   = 4'($urandom_range(0, 15));
         er  = model_write(a, dat, s);
         axi_write(a, dat, s, $urandom_range(0, 3), 1'b1, r, lat, to);
         n_checks++; if (to || lat != 0 || r !== er || user_regs !== m_flat() || ctrl_en !== m_en) begin n_fail++;
            $display("FAIL rand_write %0d a=%h: got to=%0d lat=%0d resp=%b user=%h en=%b, required resp=%b user=%h en=%b",
                     i, a, to, lat, r, user_regs, ctrl_en, er, m_flat(), m_en); end
         a = ADDR_W'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
         model_read(a, ed, er, cnt);
         axi_read(a, 1'b1, d, r, to);
         n_checks++; if (to || r !== er || (!cnt && d !== ed)) begin n_fail++;
            $display("FAIL rand_read %0d a=%h: got %h/%b, required %h/%b", i, a, d, r, ed, er); end
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] r; logic [31:0] d; int lat; bit to;
      axi_write(16'h0004, 32'h5555_AAAA, 4'hF, 0, 1'b0, r, lat, to);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bvalid !== 1'b0 || {awready, wready, arready} !== 3'b000 || ctrl_en !== 1'b0 || user_regs !== '0) begin n_fail++;
         $display("FAIL mid_reset: got bvalid=%b rdy=%b en=%b user=%h, required all 0", bvalid, {awready, wready, arready}, ctrl_en, user_regs); end
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      void'(model_write(16'h0004, 32'hC0FF_EE00, 4'hF));
      axi_write(16'h0004, 32'hC0FF_EE00, 4'hF, 2, 1'b1, r, lat, to);
      n_checks++; if (to || lat != 0 || r !== 2'b00) begin n_fail++;
         $display("FAIL post_reset_write: got to=%0d lat=%0d resp=%b, required 0/0/00", to, lat, r); end
      axi_read(16'h0004, 1'b1, d, r, to);
      n_checks++; if (to || d !== m_scratch) begin n_fail++;
         $display("FAIL post_reset_read: got %h, required %h", d, m_scratch); end
      axi_read(16'h0014, 1'b1, d, r, to);
      n_checks++; if (to || d !== 32'd0) begin n_fail++;
         $display("FAIL post_reset_user: got %h, required 0", d); end
   endtask

   initial begin
      rst_n = 1'b0; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; arvalid = 0;
      bready = 0; rready = 0; wdata = '0; wstrb = '0; activated = 0;
      model_reset();
      repeat (3) @(negedge clk);
      test_reset();
      test_scratch();
      test_w_before_aw();
      test_decode();
      test_counter();
      test_backpressure();
      test_same_cycle();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
